// File: rtl/edge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : edge_pkg                                                     |
// | Description : Shared constants, state and operation encodings for the     |
// |               edge-detection pass sequencer.                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package edge_pkg;

    // Image side length in pixels.
    localparam int IMG_DIM    = 20;
    // Pixels moved per load cycle; also the largest filter window height.
    localparam int BIT_LENGTH = 5;

    typedef enum logic [2:0] {
        ST_LOAD_REG   = 3'd0,
        ST_SET_OP     = 3'd1,
        ST_PREPARE    = 3'd2,
        ST_LOAD_MOD   = 3'd3,
        ST_DRAIN      = 3'd4,
        ST_WRITE_BACK = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        OP_IDLE    = 3'd0,
        OP_MED_FIL = 3'd1,
        OP_GAU_FIL = 3'd2,
        OP_SOBEL   = 3'd3,
        OP_NON_MAX = 3'd4,
        OP_HYSTER  = 3'd5
    } op_t;

    // Fixed pass order of the edge pipeline.
    function automatic op_t next_op(input op_t cur);
        case (cur)
            OP_IDLE:    next_op = OP_MED_FIL;
            OP_MED_FIL: next_op = OP_GAU_FIL;
            OP_GAU_FIL: next_op = OP_SOBEL;
            OP_SOBEL:   next_op = OP_NON_MAX;
            OP_NON_MAX: next_op = OP_HYSTER;
            default:    next_op = OP_IDLE;
        endcase
    endfunction

    // Only the Gaussian pass uses the 5x5 window.
    function automatic logic is_k5(input op_t cur);
        return cur == OP_GAU_FIL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_pass_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : edge_pass_sequencer_if                                       |
// | Description : Control bus between the pass sequencer and the image         |
// |               register file / filter sub-modules.                          |
// |   load_end, mod_readable      : into the sequencer                         |
// |   load_index, op, mod_enable, ind_0..ind_4, wr_en, wr_addr, write_back,    |
// |   pad5, done, err             : out of the sequencer                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface edge_pass_sequencer_if #(
    parameter int IDX_W = 9
);
    logic             load_end;
    logic             mod_readable;
    logic [IDX_W-1:0] load_index;
    logic [2:0]       op;
    logic             mod_enable;
    logic [IDX_W-1:0] ind_0;
    logic [IDX_W-1:0] ind_1;
    logic [IDX_W-1:0] ind_2;
    logic [IDX_W-1:0] ind_3;
    logic [IDX_W-1:0] ind_4;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic             write_back;
    logic             pad5;
    logic             done;
    logic             err;

    // Sequencer side.
    modport master (
        input  load_end, mod_readable,
        output load_index, op, mod_enable, ind_0, ind_1, ind_2, ind_3, ind_4,
               wr_en, wr_addr, write_back, pad5, done, err
    );

    // Register-file / filter side.
    modport slave (
        output load_end, mod_readable,
        input  load_index, op, mod_enable, ind_0, ind_1, ind_2, ind_3, ind_4,
               wr_en, wr_addr, write_back, pad5, done, err
    );
endinterface
`default_nettype wire

// File: rtl/window_index_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : window_index_gen                                             |
// | Description : Decodes the register indices of the filter window column    |
// |               and the tmp-register write address from band/column/count.  |
// |   row, col, cnt : band row r, feed column c, output count n                |
// |   k5            : 1 = 5x5 window, 0 = 3x3 window                           |
// |   ind           : index of window rows 0..4 (0 for rows beyond K)          |
// |   wr_addr       : write address of output pixel n in band r                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module window_index_gen #(
    parameter int IMG_DIM = edge_pkg::IMG_DIM,
    parameter int IDX_W   = 9,
    parameter int CNT_W   = 5
) (
    input  wire [CNT_W-1:0] row,
    input  wire [CNT_W-1:0] col,
    input  wire [CNT_W-1:0] cnt,
    input  wire             k5,
    output logic [IDX_W-1:0] ind [edge_pkg::BIT_LENGTH],
    output logic [IDX_W-1:0] wr_addr
);
    import edge_pkg::*;

    int w_k;
    int w_half;

    assign w_k    = k5 ? 5 : 3;
    assign w_half = w_k / 2;

    generate
        for (genvar k = 0; k < BIT_LENGTH; k++) begin : g_row
            assign ind[k] = (k < w_k)
                          ? IDX_W'((int'(row) + k) * IMG_DIM + int'(col))
                          : '0;
        end
    endgenerate

    // Output pixel n lands at the window centre: offset by half in both axes.
    assign wr_addr = IDX_W'((int'(row) + w_half) * IMG_DIM + w_half + int'(cnt));

endmodule
`default_nettype wire

// File: rtl/edge_pass_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : edge_pass_sequencer                                          |
// | Description : Sequences image load and the five filter passes (median,    |
// |               Gaussian, Sobel, non-max, hysteresis) band by band, feeding |
// |               window columns to the active filter and collecting its      |
// |               output pixels into the tmp register file.                    |
// |   clk, reset : clock and asynchronous active-high reset                    |
// |   bus        : edge_pass_sequencer_if master modport (see interface)       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module edge_pass_sequencer #(
    parameter int IMG_DIM = edge_pkg::IMG_DIM,
    parameter int IDX_W   = 9
) (
    input  wire                   clk,
    input  wire                   reset,
    edge_pass_sequencer_if.master bus
);
    import edge_pkg::*;

    localparam int c_cnt_w = $clog2(IMG_DIM + 1);
    // Outputs per band (and bands per pass) is IMG_DIM-K+1.
    localparam logic [c_cnt_w-1:0] c_lim_k3    = c_cnt_w'(IMG_DIM - 2);
    localparam logic [c_cnt_w-1:0] c_lim_k5    = c_cnt_w'(IMG_DIM - 4);
    localparam logic [c_cnt_w-1:0] c_col_last  = c_cnt_w'(IMG_DIM - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [IDX_W-1:0]   c_load_max  = IDX_W'(IMG_DIM * IMG_DIM - BIT_LENGTH);
    localparam logic [IDX_W-1:0]   c_load_step = IDX_W'(BIT_LENGTH);

    state_t             r_state, w_state_next;
    op_t                r_op, w_op_next;
    logic [IDX_W-1:0]   r_load_index, w_load_index_next;
    logic [c_cnt_w-1:0] r_row, w_row_next;
    logic [c_cnt_w-1:0] r_col, w_col_next;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_next;
    logic               r_err, w_err_next;

    logic               w_k5;
    logic [c_cnt_w-1:0] w_lim;
    logic               w_in_feed;
    logic               w_accept;
    logic [c_cnt_w-1:0] w_cnt_acc;
    logic [IDX_W-1:0]   w_ind [BIT_LENGTH];
    logic [IDX_W-1:0]   w_wr_addr;

    assign w_k5      = is_k5(r_op);
    assign w_lim     = w_k5 ? c_lim_k5 : c_lim_k3;
    assign w_in_feed = (r_state == ST_LOAD_MOD) || (r_state == ST_DRAIN);
    // A filter output is only taken while the band still expects one.
    assign w_accept  = w_in_feed && bus.mod_readable && (r_cnt != w_lim);
    assign w_cnt_acc = w_accept ? (r_cnt + c_cnt_one) : r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_LOAD_REG;
            r_op         <= OP_IDLE;
            r_load_index <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_op         <= w_op_next;
            r_load_index <= w_load_index_next;
            r_row        <= w_row_next;
            r_col        <= w_col_next;
            r_cnt        <= w_cnt_next;
            r_err        <= w_err_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_op_next         = r_op;
        w_load_index_next = r_load_index;
        w_row_next        = r_row;
        w_col_next        = r_col;
        w_cnt_next        = w_cnt_acc;
        // Any filter output that is not accepted is a protocol violation.
        w_err_next        = r_err | (bus.mod_readable & ~w_accept);

        case (r_state)
            ST_LOAD_REG: begin
                w_load_index_next = (r_load_index >= c_load_max)
                                  ? c_load_max : (r_load_index + c_load_step);
                if (bus.load_end) begin
                    w_state_next = ST_SET_OP;
                end
            end
            ST_SET_OP: begin
                w_op_next    = next_op(r_op);
                w_row_next   = '0;
                w_state_next = ST_PREPARE;
            end
            ST_PREPARE: begin
                // r <= IMG_DIM-K is the same test as r < IMG_DIM-K+1.
                if (r_row < w_lim) begin
                    w_col_next   = '0;
                    w_cnt_next   = '0;
                    w_state_next = ST_LOAD_MOD;
                end else if (r_op == OP_HYSTER) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_WRITE_BACK;
                end
            end
            ST_LOAD_MOD: begin
                w_col_next = r_col + c_cnt_one;
                if (r_col == c_col_last) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Counts the write accepted this very cycle.
                if (w_cnt_acc == w_lim) begin
                    w_row_next   = r_row + c_cnt_one;
                    w_state_next = ST_PREPARE;
                end
            end
            ST_WRITE_BACK: begin
                w_state_next = ST_SET_OP;
            end
            ST_DONE: begin
                w_op_next         = OP_IDLE;
                w_load_index_next = '0;
                w_state_next      = ST_LOAD_REG;
            end
            default: begin
                w_state_next = ST_LOAD_REG;
            end
        endcase
    end

    window_index_gen #(
        .IMG_DIM (IMG_DIM),
        .IDX_W   (IDX_W),
        .CNT_W   (c_cnt_w)
    ) u_window_index_gen (
        .row     (r_row),
        .col     (r_col),
        .cnt     (r_cnt),
        .k5      (w_k5),
        .ind     (w_ind),
        .wr_addr (w_wr_addr)
    );

    assign bus.load_index = r_load_index;
    assign bus.op         = r_op;
    assign bus.err        = r_err;
    assign bus.mod_enable = (r_state == ST_LOAD_MOD);
    assign bus.ind_0      = w_ind[0];
    assign bus.ind_1      = w_ind[1];
    assign bus.ind_2      = w_ind[2];
    assign bus.ind_3      = w_ind[3];
    assign bus.ind_4      = w_ind[4];
    assign bus.wr_en      = w_accept;
    assign bus.wr_addr    = w_wr_addr;
    assign bus.write_back = (r_state == ST_WRITE_BACK);
    assign bus.pad5       = (r_state == ST_WRITE_BACK) && w_k5;
    assign bus.done       = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_edge_pass_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_edge_pass_sequencer                                       |
// | Description : Directed self-checking bench for edge_pass_sequencer.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_edge_pass_sequencer;

    localparam int D = 20;

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_fail = 0;

    // Per-pass observations gathered by run_pass.
    int p_end, p_bands, p_writes, p_first, p_last, p_ind2, p_ind4;
    int p_wb, p_pad5, p_done, p_err;
    int wb_total;
    int wcnt;

    always #5 clk = ~clk;

    edge_pass_sequencer_if #(.IDX_W(9)) bus ();

    edge_pass_sequencer #(
        .IMG_DIM (D),
        .IDX_W   (9)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one pass starting in PREPARE. A filter model answers each enabled
    // column c >= kk-1 with a mod_readable pulse two cycles later.
    task automatic run_pass(input int kk);
        int   col_seen;
        logic pipe0, pipe1, prev_en, elig;
        col_seen = 0; pipe0 = 1'b0; pipe1 = 1'b0; prev_en = 1'b0;
        p_end = 0; p_bands = 0; p_writes = 0; p_first = -1; p_last = -1;
        p_ind2 = -1; p_ind4 = -1; p_wb = 0; p_pad5 = 0; p_done = 0; p_err = 0;
        for (int cyc = 0; cyc < 2000 && p_end == 0; cyc++) begin
            bus.mod_readable = pipe1;
            #1;
            if (bus.wr_en) begin
                if (p_writes == 0) p_first = int'(bus.wr_addr);
                p_last = int'(bus.wr_addr);
                p_writes++;
            end
            if (bus.mod_enable && !prev_en) begin
                p_bands++;
                if (p_bands == 1) begin
                    p_ind2 = int'(bus.ind_2);
                    p_ind4 = int'(bus.ind_4);
                end
            end
            if (bus.err) p_err = 1;
            elig = bus.mod_enable && ((col_seen % D) >= kk - 1);
            if (bus.mod_enable) col_seen++;
            prev_en = bus.mod_enable;
            pipe1 = pipe0;
            pipe0 = elig;
            if (bus.write_back || bus.done) begin
                p_end  = 1;
                p_wb   = int'(bus.write_back);
                p_pad5 = int'(bus.pad5);
                p_done = int'(bus.done);
            end else begin
                step();
            end
        end
        bus.mod_readable = 1'b0;
        check("pass_terminates", p_end, 1);
        wb_total += p_wb;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wb_total         = 0;
        reset            = 1'b1;
        bus.load_end     = 1'b0;
        bus.mod_readable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_load_index", 32'(bus.load_index), 0);
        check("rst_op",         32'(bus.op), 0);
        check("rst_err",        32'(bus.err), 0);
        check("rst_mod_enable", 32'(bus.mod_enable), 0);
        check("rst_wr_en",      32'(bus.wr_en), 0);
        check("rst_write_back", 32'(bus.write_back), 0);
        check("rst_done",       32'(bus.done), 0);

        // Image load: +5 per cycle, saturating at 395.
        reset = 1'b0;
        repeat (10) step();
        check("load_index_10", 32'(bus.load_index), 50);
        repeat (69) step();
        check("load_index_79", 32'(bus.load_index), 395);
        bus.load_end = 1'b1;
        step();
        bus.load_end = 1'b0;
        check("load_index_held", 32'(bus.load_index), 395);
        check("op_in_set_op",    32'(bus.op), 0);
        step();
        check("op_med",          32'(bus.op), 1);
        check("prep_no_enable",  32'(bus.mod_enable), 0);

        // Median 3x3 pass.
        run_pass(3);
        check("med_bands",  p_bands, 18);
        check("med_writes", p_writes, 324);
        check("med_first",  p_first, 21);
        check("med_last",   p_last, 378);
        check("med_ind2",   p_ind2, 40);
        check("med_ind4",   p_ind4, 0);
        check("med_wb",     p_wb, 1);
        check("med_pad5",   p_pad5, 0);
        check("med_err",    p_err, 0);
        step(); step();
        check("op_gau", 32'(bus.op), 2);

        // Gaussian 5x5 pass.
        run_pass(5);
        check("gau_bands",  p_bands, 16);
        check("gau_writes", p_writes, 256);
        check("gau_first",  p_first, 42);
        check("gau_last",   p_last, 357);
        check("gau_ind4",   p_ind4, 80);
        check("gau_wb",     p_wb, 1);
        check("gau_pad5",   p_pad5, 1);
        step(); step();
        check("op_sobel", 32'(bus.op), 3);
        run_pass(3);
        check("sobel_writes", p_writes, 324);
        check("sobel_pad5",   p_pad5, 0);
        step(); step();
        check("op_nonmax", 32'(bus.op), 4);
        run_pass(3);
        check("nonmax_writes", p_writes, 324);
        step(); step();
        check("op_hyster", 32'(bus.op), 5);
        run_pass(3);
        check("hyst_writes", p_writes, 324);
        check("hyst_done",   p_done, 1);
        check("hyst_no_wb",  p_wb, 0);
        check("wb_total",    wb_total, 4);
        check("run_err",     p_err, 0);
        step();
        check("post_done_op",    32'(bus.op), 0);
        check("post_done_index", 32'(bus.load_index), 0);
        check("post_done_pulse", 32'(bus.done), 0);
        step();
        check("reload_index", 32'(bus.load_index), 5);

        // Overrun: readable every cycle gives 18 writes, the 19th is refused.
        bus.load_end = 1'b1;
        step();
        bus.load_end = 1'b0;
        step(); step();
        check("ovr_enable", 32'(bus.mod_enable), 1);
        bus.mod_readable = 1'b1;
        wcnt = 0;
        for (int i = 0; i < 18; i++) begin
            #1;
            if (bus.wr_en) wcnt++;
            step();
        end
        check("ovr_writes", wcnt, 18);
        #1;
        check("ovr_no_wr_en",  32'(bus.wr_en), 0);
        check("ovr_err_clear", 32'(bus.err), 0);
        step();
        bus.mod_readable = 1'b0;
        check("ovr_err_set", 32'(bus.err), 1);
        repeat (30) step();
        check("ovr_err_sticky", 32'(bus.err), 1);
        reset = 1'b1;
        step();
        check("ovr_err_reset", 32'(bus.err), 0);
        reset = 1'b0;

        // Stray readable while loading.
        bus.mod_readable = 1'b1;
        #1;
        check("stray_no_wr_en", 32'(bus.wr_en), 0);
        step();
        bus.mod_readable = 1'b0;
        check("stray_err", 32'(bus.err), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Reset during the Sobel pass aborts it.
        bus.load_end = 1'b1;
        step();
        bus.load_end = 1'b0;
        step();
        run_pass(3);
        step(); step();
        run_pass(5);
        step(); step();
        step();
        repeat (5) step();
        check("abort_enable", 32'(bus.mod_enable), 1);
        check("abort_op",     32'(bus.op), 3);
        reset = 1'b1;
        #1;
        check("abort_op_idle",   32'(bus.op), 0);
        check("abort_no_enable", 32'(bus.mod_enable), 0);
        step();
        check("abort_no_wb",   32'(bus.write_back), 0);
        check("abort_no_done", 32'(bus.done), 0);
        reset = 1'b0;
        step();
        check("abort_loading", 32'(bus.load_index), 5);
        check("abort_op_after", 32'(bus.op), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
